mem_arbiter: RTL

Shares the single external RAM port (IRAM controller side) between the fetch unit's instruction-cache line refill and the memory stage's single-word data load/store. Instruction misses are served as fixed-length line bursts and data accesses as single beats. Simultaneous requests are granted alternately, so neither requester starves. Sits between `riscv_core` (fetch unit miss path, memory stage) and the RAM controller.

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external RAM port between instruction-cache line
// refills (LINE_WORDS-beat bursts) and single-beat data loads/stores.
// Simultaneous requests are granted alternately. A grant is never preempted.
//
// Ports:
//   clk, nrst                        clock, synchronous active-low reset
//   ic_req/ic_addr                   line refill request (level, held to ic_done)
//   ic_word/ic_word_idx/ic_word_valid  refilled word stream, one pulse per word
//   ic_done                          refill complete pulse (with the last word)
//   dc_req/dc_we/dc_addr/dc_wdata    data access request (level, held to dc_done)
//   dc_rdata/dc_done                 load data (held) and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready  RAM beat interface
//   busy                             arbiter not idle
// All outputs are registered.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic [DATA_W-1:0]             ic_word,
  output logic [$clog2(LINE_WORDS)-1:0] ic_word_idx,
  output logic                          ic_word_valid,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_W-1:0]             dc_addr,
  input  logic [DATA_W-1:0]             dc_wdata,
  output logic [DATA_W-1:0]             dc_rdata,
  output logic                          dc_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  // byte-offset bits covered by one cache line
  localparam int OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IBURST = 2'd1,
    S_DATA   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  beat, beat_n;
  logic [IDX_W-1:0]  beat_inc;
  // last_data: 1 when the most recent completed grant went to the data side
  logic              last_data, last_data_n;
  // cur_data: 1 while the current grant belongs to the data side
  logic              cur_data, cur_data_n;

  logic [DATA_W-1:0] ic_word_n;
  logic [IDX_W-1:0]  ic_word_idx_n;
  logic              ic_word_valid_n;
  logic              ic_done_n;
  logic [DATA_W-1:0] dc_rdata_n;
  logic              dc_done_n;
  logic              mem_req_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              busy_n;

  logic              grant_d;
  logic              grant_i;
  logic              accept;

  assign beat_inc = beat + 1'b1;
  // a ready pulse only counts while a beat is actually being requested
  assign accept   = mem_ready && mem_req;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= S_IDLE;
      beat          <= '0;
      last_data     <= 1'b0;
      cur_data      <= 1'b0;
      ic_word       <= '0;
      ic_word_idx   <= '0;
      ic_word_valid <= 1'b0;
      ic_done       <= 1'b0;
      dc_rdata      <= '0;
      dc_done       <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      last_data     <= last_data_n;
      cur_data      <= cur_data_n;
      ic_word       <= ic_word_n;
      ic_word_idx   <= ic_word_idx_n;
      ic_word_valid <= ic_word_valid_n;
      ic_done       <= ic_done_n;
      dc_rdata      <= dc_rdata_n;
      dc_done       <= dc_done_n;
      mem_req       <= mem_req_n;
      mem_we        <= mem_we_n;
      mem_addr      <= mem_addr_n;
      mem_wdata     <= mem_wdata_n;
      busy          <= busy_n;
    end
  end

  always_comb begin
    state_n         = state;
    beat_n          = beat;
    last_data_n     = last_data;
    cur_data_n      = cur_data;
    ic_word_n       = ic_word;
    ic_word_idx_n   = ic_word_idx;
    ic_word_valid_n = 1'b0;
    ic_done_n       = 1'b0;
    dc_rdata_n      = dc_rdata;
    dc_done_n       = 1'b0;
    mem_req_n       = mem_req;
    mem_we_n        = mem_we;
    mem_addr_n      = mem_addr;
    mem_wdata_n     = mem_wdata;

    // Tie goes to whichever side did not win last time.
    grant_d = dc_req && (!ic_req || !last_data);
    grant_i = ic_req && !grant_d;

    case (state)
      S_IDLE: begin
        if (grant_d) begin
          // mem_we/mem_addr/mem_wdata double as the latched request fields
          state_n     = S_DATA;
          cur_data_n  = 1'b1;
          mem_req_n   = 1'b1;
          mem_we_n    = dc_we;
          mem_addr_n  = {dc_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_n = dc_wdata;
        end else if (grant_i) begin
          // line base stays in mem_addr's upper bits for the whole burst
          state_n    = S_IBURST;
          cur_data_n = 1'b0;
          beat_n     = '0;
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = {ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end

      S_DATA: begin
        if (accept) begin
          state_n   = S_RESP;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          dc_done_n = 1'b1;
          if (!mem_we) begin
            dc_rdata_n = mem_rdata;
          end
        end
      end

      S_IBURST: begin
        if (accept) begin
          ic_word_n       = mem_rdata;
          ic_word_idx_n   = beat;
          ic_word_valid_n = 1'b1;
          beat_n          = beat_inc;
          if (beat == LAST_BEAT) begin
            // done is raised together with the final word
            state_n   = S_RESP;
            mem_req_n = 1'b0;
            ic_done_n = 1'b1;
          end else begin
            mem_addr_n = {mem_addr[ADDR_W-1:OFF_W], beat_inc, 2'b00};
          end
        end
      end

      S_RESP: begin
        // done pulse is already on the outputs; one IDLE cycle follows so a
        // requester that drops req after done is never re-sampled
        state_n     = S_IDLE;
        last_data_n = cur_data;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule
